sprite_mem_arb: RTL and testbench

//   Arbitrates one single-port, synchronous-read sprite attribute memory between the EX

---
 rtl/sprite_mem_arb_if.sv | 47 ++++
 rtl/sprite_mem_arb.sv | 118 +++++++++++
 tb/tb_sprite_mem_arb.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_mem_arb_if.sv
// Bundle of the CPU access port, the graphics burst port and the sprite memory port.
// The arbiter attaches through the slave modport; the requesters and memory use master.
interface sprite_mem_arb_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              gfx_req;
    logic [ADDR_W-1:0] gfx_addr;
    logic [3:0]        gfx_len;
    logic              gfx_gnt;
    logic              gfx_busy;
    logic [DATA_W-1:0] gfx_rdata;
    logic              gfx_rvalid;
    logic              gfx_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  gfx_req, gfx_addr, gfx_len,
        output gfx_gnt, gfx_busy, gfx_rdata, gfx_rvalid, gfx_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output gfx_req, gfx_addr, gfx_len,
        input  gfx_gnt, gfx_busy, gfx_rdata, gfx_rvalid, gfx_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/sprite_mem_arb.sv
// Sprite attribute memory arbiter: graphics bursts have priority, a starvation counter
// guarantees the CPU a slot, and read data is steered back to whoever issued the read.
module sprite_mem_arb #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    sprite_mem_arb_if.slave bus
);
    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state;
    logic [ADDR_W-1:0] burst_addr;
    logic [3:0]        remaining;
    logic [SW-1:0]     starve;

    logic              rd_vld_p1;
    logic              rd_gfx_p1;
    logic              rd_last_p1;

    logic              starved;
    logic              cpu_gnt;
    logic              gfx_accept;
    logic              burst_issue;
    logic              burst_last;

    function automatic logic [SW-1:0] starve_next(input logic [SW-1:0] cur,
                                                  input logic          req,
                                                  input logic          gnt);
        if (!req || gnt)
            return '0;
        else if (cur == STARVE_TOP)
            return cur;
        else
            return cur + SW'(1);
    endfunction

    always_comb begin
        starved     = (starve == STARVE_TOP);
        cpu_gnt     = 1'b0;
        gfx_accept  = 1'b0;
        burst_issue = 1'b0;
        case (state)
            IDLE: begin
                cpu_gnt    = bus.cpu_req & (~bus.gfx_req | starved);
                gfx_accept = bus.gfx_req & ~cpu_gnt;
            end
            BURST: begin
                // A starved CPU steals the slot; the burst simply pauses in place.
                cpu_gnt     = bus.cpu_req & starved;
                burst_issue = ~cpu_gnt;
            end
            default: begin
                cpu_gnt = 1'b0;
            end
        endcase
        burst_last = burst_issue & (remaining == 4'd0);
    end

    // Issue stage: everything toward the memory is gated so reset forces it quiet at once.
    assign bus.cpu_stall = rst_n & bus.cpu_req & ~cpu_gnt;
    assign bus.gfx_gnt   = rst_n & gfx_accept;
    assign bus.gfx_busy  = (state == BURST);
    assign bus.mem_en    = rst_n & (cpu_gnt | burst_issue);
    assign bus.mem_we    = rst_n & cpu_gnt & bus.cpu_we;
    assign bus.mem_addr  = (!rst_n)    ? '0 :
                           cpu_gnt     ? bus.cpu_addr :
                           burst_issue ? burst_addr : '0;
    assign bus.mem_wdata = (rst_n && cpu_gnt && bus.cpu_we) ? bus.cpu_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            burst_addr <= '0;
            remaining  <= '0;
            starve     <= '0;
            rd_vld_p1  <= 1'b0;
            rd_gfx_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
        end else begin
            starve     <= starve_next(starve, bus.cpu_req, cpu_gnt);
            rd_vld_p1  <= (cpu_gnt & ~bus.cpu_we) | burst_issue;
            rd_gfx_p1  <= burst_issue;
            rd_last_p1 <= burst_last;
            case (state)
                IDLE: begin
                    if (gfx_accept) begin
                        burst_addr <= bus.gfx_addr;
                        remaining  <= bus.gfx_len;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (burst_issue) begin
                        burst_addr <= burst_addr + ADDR_W'(1);
                        remaining  <= remaining - 4'd1;
                        if (remaining == 4'd0)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Return stage: one cycle after issue, data goes to the recorded owner only.
    assign bus.cpu_rvalid = rd_vld_p1 & ~rd_gfx_p1;
    assign bus.gfx_rvalid = rd_vld_p1 & rd_gfx_p1;
    assign bus.gfx_done   = rd_vld_p1 & rd_gfx_p1 & rd_last_p1;
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
    assign bus.gfx_rdata  = bus.gfx_rvalid ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_sprite_mem_arb.sv
// Directed bench for sprite_mem_arb with a behavioural sprite memory and a scoreboard
// that pairs each returned beat with the value expected when the read was issued.
module tb_sprite_mem_arb;
    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 8;
    localparam int STARVE_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sprite_mem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sprite_mem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       done;
    } exp_t;

    exp_t cpu_q[$];
    exp_t gfx_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] wmem    [0:4095];
    bit         written [0:4095];

    // Preset contents of every location that has not been written.
    function automatic logic [7:0] pat(input logic [11:0] a);
        return a[7:0] + {a[11:8], 4'h0} + 8'h11;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                wmem[bus.mem_addr]    <= bus.mem_wdata;
                written[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= written[bus.mem_addr] ? wmem[bus.mem_addr] : pat(bus.mem_addr);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (bus.cpu_rvalid) begin
            if (cpu_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL cpu_rvalid_unexpected actual=1 required=0");
            end else begin
                e = cpu_q.pop_front();
                chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(e.data));
            end
        end else begin
            chk("cpu_rdata_when_invalid", 64'(bus.cpu_rdata), 64'd0);
        end
        if (bus.gfx_rvalid) begin
            if (gfx_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL gfx_rvalid_unexpected actual=1 required=0");
            end else begin
                e = gfx_q.pop_front();
                chk("gfx_rdata", 64'(bus.gfx_rdata), 64'(e.data));
                chk("gfx_done", 64'(bus.gfx_done), 64'(e.done));
            end
        end else begin
            chk("gfx_rdata_when_invalid", 64'(bus.gfx_rdata), 64'd0);
            chk("gfx_done_when_invalid", 64'(bus.gfx_done), 64'd0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic neg;
        @(negedge clk);
    endtask

    task automatic push_cpu(input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.done = 1'b0;
        cpu_q.push_back(e);
    endtask

    task automatic push_gfx(input logic [7:0] d, input logic last);
        exp_t e;
        e.data = d;
        e.done = last;
        gfx_q.push_back(e);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({bus.cpu_stall, bus.cpu_rdata, bus.cpu_rvalid, bus.gfx_gnt, bus.gfx_busy,
                    bus.gfx_rdata, bus.gfx_rvalid, bus.gfx_done, bus.mem_en, bus.mem_we,
                    bus.mem_addr, bus.mem_wdata});
    endfunction

    task automatic gfx_request(input logic [11:0] a, input logic [3:0] len);
        bus.gfx_req  = 1'b1;
        bus.gfx_addr = a;
        bus.gfx_len  = len;
        neg;
        chk("gnt_pulse", 64'(bus.gfx_gnt), 64'd1);
        chk("gnt_no_access", 64'(bus.mem_en), 64'd0);
        chk("gnt_not_busy", 64'(bus.gfx_busy), 64'd0);
        tick;
        bus.gfx_req  = 1'b0;
        bus.gfx_addr = '0;
        bus.gfx_len  = '0;
    endtask

    task automatic run_burst(input logic [11:0] a, input logic [3:0] len);
        logic [11:0] ad;
        gfx_request(a, len);
        for (int i = 0; i <= int'(len); i++) begin
            ad = a + 12'(i);
            neg;
            chk("burst_busy", 64'(bus.gfx_busy), 64'd1);
            chk("burst_gnt_low", 64'(bus.gfx_gnt), 64'd0);
            chk("burst_en", 64'(bus.mem_en), 64'd1);
            chk("burst_we", 64'(bus.mem_we), 64'd0);
            chk("burst_addr", 64'(bus.mem_addr), 64'(ad));
            chk("burst_rvalid_timing", 64'(bus.gfx_rvalid), 64'(i > 0));
            push_gfx(pat(ad), i == int'(len));
            tick;
        end
        neg;
        chk("burst_end_busy", 64'(bus.gfx_busy), 64'd0);
        chk("burst_end_rvalid", 64'(bus.gfx_rvalid), 64'd1);
        chk("burst_end_done", 64'(bus.gfx_done), 64'd1);
        tick;
    endtask

    initial begin
        int beat;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.gfx_req   = 1'b0;
        bus.gfx_addr  = '0;
        bus.gfx_len   = '0;

        // Reset state
        neg;
        chk("reset_outputs", all_outputs(), 64'd0);
        tick;
        rst_n = 1'b1;
        neg;
        chk("post_reset_outputs", all_outputs(), 64'd0);
        tick;

        // Test 1: idle CPU write then read
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 12'h123;
        bus.cpu_wdata = 8'hA5;
        neg;
        chk("t1_wr_stall", 64'(bus.cpu_stall), 64'd0);
        chk("t1_wr_en", 64'(bus.mem_en), 64'd1);
        chk("t1_wr_we", 64'(bus.mem_we), 64'd1);
        chk("t1_wr_addr", 64'(bus.mem_addr), 64'h123);
        chk("t1_wr_data", 64'(bus.mem_wdata), 64'hA5);
        tick;
        bus.cpu_we    = 1'b0;
        bus.cpu_wdata = '0;
        neg;
        chk("t1_wr_no_rvalid", 64'(bus.cpu_rvalid), 64'd0);
        chk("t1_rd_stall", 64'(bus.cpu_stall), 64'd0);
        chk("t1_rd_en", 64'(bus.mem_en), 64'd1);
        chk("t1_rd_we", 64'(bus.mem_we), 64'd0);
        chk("t1_rd_addr", 64'(bus.mem_addr), 64'h123);
        push_cpu(8'hA5);
        tick;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = '0;
        neg;
        chk("t1_rvalid_next_cycle", 64'(bus.cpu_rvalid), 64'd1);
        tick;

        // Test 2 and 3: bursts, including address wrap
        run_burst(12'h0FE, 4'd3);
        run_burst(12'hFFE, 4'd3);

        // Test 4: starved CPU steals one slot in a long burst
        gfx_request(12'h200, 4'd15);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 12'h345;
        beat = 0;
        for (int k = 0; k < 17; k++) begin
            neg;
            chk("t4_busy", 64'(bus.gfx_busy), 64'd1);
            if (k == 4) begin
                chk("t4_cpu_granted", 64'(bus.cpu_stall), 64'd0);
                chk("t4_cpu_addr", 64'(bus.mem_addr), 64'h345);
                chk("t4_cpu_we", 64'(bus.mem_we), 64'd0);
                push_cpu(pat(12'h345));
                tick;
                bus.cpu_req  = 1'b0;
                bus.cpu_addr = '0;
            end else begin
                chk("t4_stall", 64'(bus.cpu_stall), 64'(k < 4));
                chk("t4_beat_addr", 64'(bus.mem_addr), 64'(12'h200 + 12'(beat)));
                push_gfx(pat(12'h200 + 12'(beat)), beat == 15);
                beat++;
                tick;
            end
        end
        neg;
        chk("t4_end_busy", 64'(bus.gfx_busy), 64'd0);
        chk("t4_end_idle_en", 64'(bus.mem_en), 64'd0);
        chk("t4_end_done", 64'(bus.gfx_done), 64'd1);
        tick;

        // Test 5: simultaneous requests with no starvation history
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 12'h050;
        bus.gfx_req  = 1'b1;
        bus.gfx_addr = 12'h300;
        bus.gfx_len  = 4'd0;
        neg;
        chk("t5_gnt", 64'(bus.gfx_gnt), 64'd1);
        chk("t5_stall", 64'(bus.cpu_stall), 64'd1);
        chk("t5_no_access", 64'(bus.mem_en), 64'd0);
        tick;
        bus.gfx_req  = 1'b0;
        bus.gfx_addr = '0;
        neg;
        chk("t5_starve_one", 64'(dut.starve), 64'd1);
        chk("t5_burst_stall", 64'(bus.cpu_stall), 64'd1);
        chk("t5_burst_addr", 64'(bus.mem_addr), 64'h300);
        push_gfx(pat(12'h300), 1'b1);
        tick;
        neg;
        chk("t5_cpu_granted", 64'(bus.cpu_stall), 64'd0);
        chk("t5_cpu_addr", 64'(bus.mem_addr), 64'h050);
        chk("t5_idle", 64'(bus.gfx_busy), 64'd0);
        push_cpu(pat(12'h050));
        tick;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = '0;
        neg;
        tick;

        // Test 6: reset in the middle of a burst
        gfx_request(12'h400, 4'd7);
        neg;
        chk("t6_beat1_addr", 64'(bus.mem_addr), 64'h400);
        push_gfx(pat(12'h400), 1'b0);
        tick;
        neg;
        chk("t6_beat2_addr", 64'(bus.mem_addr), 64'h401);
        tick;
        rst_n        = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 12'h123;
        neg;
        chk("t6_reset_outputs", all_outputs(), 64'd0);
        chk("t6_first_beat_returned", 64'(gfx_q.size()), 64'd0);
        tick;
        neg;
        chk("t6_reset_outputs_held", all_outputs(), 64'd0);
        tick;
        rst_n       = 1'b1;
        bus.cpu_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            neg;
            chk("t6_after_busy", 64'(bus.gfx_busy), 64'd0);
            chk("t6_after_rvalid", 64'(bus.gfx_rvalid), 64'd0);
            chk("t6_after_done", 64'(bus.gfx_done), 64'd0);
            tick;
        end
        bus.cpu_req = 1'b1;
        neg;
        chk("t6_idle_cpu_stall", 64'(bus.cpu_stall), 64'd0);
        chk("t6_idle_cpu_en", 64'(bus.mem_en), 64'd1);
        push_cpu(8'hA5);
        tick;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = '0;
        neg;
        tick;
        neg;
        chk("cpu_queue_drained", 64'(cpu_q.size()), 64'd0);
        chk("gfx_queue_drained", 64'(gfx_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
